// File: rtl/imm_buf.sv
`default_nettype none
// ============================================================================
// Module  : imm_buf
// Brief   : Row-allocated immediate buffer with busy-bit free list, masked
//           lane writes, per-entry valid bits, row release and flush.
// Revision: 1.0 - initial release
// ============================================================================
module imm_buf #(
   parameter  int SIZE   = 32,
   parameter  int WIDTH  = 32,
   parameter  int LANES  = 4,
   parameter  int RPORTS = 4,
   localparam int ROWS   = SIZE / LANES,
   localparam int AW     = $clog2(SIZE),
   localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int CW     = $clog2(ROWS + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_alloc,
   output logic                    o_alloc_rdy,
   output logic [RW-1:0]           o_alloc_row,
   output logic [CW-1:0]           o_free_cnt,
   input  logic                    i_we,
   input  logic [RW-1:0]           i_wrow,
   input  logic [LANES-1:0]        i_wmask,
   input  logic [LANES*WIDTH-1:0]  i_wdata,
   input  logic [ROWS-1:0]         i_free,
   input  logic                    i_flush,
   input  logic [RPORTS*AW-1:0]    i_raddr,
   output logic [RPORTS*WIDTH-1:0] o_rdata,
   output logic [RPORTS-1:0]       o_rvalid
);

   logic [ROWS-1:0]  busy_q, busy_d;
   logic [SIZE-1:0]  valid_q, valid_d;
   logic [CW-1:0]    free_cnt_q, free_cnt_d;
   logic [WIDTH-1:0] data_q [SIZE];
   logic [WIDTH-1:0] data_d [SIZE];

   logic [RW-1:0]    alloc_row;
   logic             alloc_ok;
   logic [CW-1:0]    rel_cnt;

   // Lowest-index free row wins; scanning downward leaves the lowest hit last.
   always_comb begin
      alloc_row = '0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (!busy_q[r]) alloc_row = RW'(r);
      end
   end

   assign o_alloc_rdy = |(~busy_q);
   assign o_alloc_row = alloc_row;
   assign o_free_cnt  = free_cnt_q;
   assign alloc_ok    = i_alloc & o_alloc_rdy;

   // Order matters: write, then free (so free beats write), then allocate
   // (so a free bit on an already-free row cannot cancel a grant).
   always_comb begin
      busy_d  = busy_q;
      valid_d = valid_q;
      data_d  = data_q;
      rel_cnt = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (i_we && (i_wrow == RW'(r)) && busy_q[r]) begin
            for (int k = 0; k < LANES; k++) begin
               if (i_wmask[k]) begin
                  data_d[r*LANES + k]  = i_wdata[k*WIDTH +: WIDTH];
                  valid_d[r*LANES + k] = 1'b1;
               end
            end
         end
      end
      for (int r = 0; r < ROWS; r++) begin
         if (i_free[r]) begin
            rel_cnt                  = rel_cnt + CW'(busy_q[r]);
            busy_d[r]                = 1'b0;
            valid_d[r*LANES +: LANES] = '0;
         end
      end
      for (int r = 0; r < ROWS; r++) begin
         if (alloc_ok && (alloc_row == RW'(r))) busy_d[r] = 1'b1;
      end
      free_cnt_d = free_cnt_q + rel_cnt - CW'(alloc_ok);
      if (i_flush) begin
         busy_d     = '0;
         valid_d    = '0;
         free_cnt_d = CW'(ROWS);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         busy_q     <= '0;
         valid_q    <= '0;
         free_cnt_q <= CW'(ROWS);
      end else begin
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         free_cnt_q <= free_cnt_d;
      end
   end

   // Payload storage is never reset; stale contents are hidden by valid_q.
   always_ff @(posedge i_clk) begin
      data_q <= data_d;
   end

   generate
      for (genvar p = 0; p < RPORTS; p++) begin : g_rd
         logic [AW-1:0] raddr;
         assign raddr = i_raddr[p*AW +: AW];
         always_comb begin
            o_rdata[p*WIDTH +: WIDTH] = '0;
            o_rvalid[p]               = 1'b0;
            if ({1'b0, raddr} < (AW+1)'(SIZE)) begin
               o_rdata[p*WIDTH +: WIDTH] = data_q[raddr];
               o_rvalid[p]               = valid_q[raddr];
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: doc/imm_buf.md
Name: imm_buf

Overview:
- Parametrised successor to the 4-lane immediate store: holds decoded immediates for a dispatch bundle of LANES instructions.
- Owns row allocation internally through a busy-bit free list. Supports per-lane masked writes, per-entry valid bits, out-of-order row release, and whole-buffer flush.
- Sits between decode/rename, which allocates and writes, and the issue queues/execute, which read and then free.

Parameters:
- SIZE, 32, total entries; must be a multiple of LANES.
- WIDTH, 32, bits per immediate.
- LANES, 4, entries per row (bundle width); power of two, at least 1.
- RPORTS, 4, number of independent read ports.
- Derived values: ROWS = SIZE/LANES; AW = $clog2(SIZE); RW = max(1, $clog2(ROWS)); CW = $clog2(ROWS+1).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_alloc  in  1  request one row this cycle.
- o_alloc_rdy  out  1  at least one row is free.
- o_alloc_row  out  RW  row granted if i_alloc is high this cycle.
- o_free_cnt  out  CW  number of free rows (registered).
- i_we  in  1  write enable.
- i_wrow  in  RW  row to write.
- i_wmask  in  LANES  per-lane write mask.
- i_wdata  in  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- i_free  in  ROWS  one-hot or multi-hot row release mask.
- i_flush  in  1  release all rows.
- i_raddr  in  RPORTS*AW  read addresses; entry index = row*LANES + lane.
- o_rdata  out  RPORTS*WIDTH  read data.
- o_rvalid  out  RPORTS  valid bit of each addressed entry.

Behaviour:
- State:
  - busy[ROWS]
  - valid[SIZE]
  - data[SIZE][WIDTH], not reset
  - free counter
- Reset (asynchronous, takes effect immediately and at any point mid-operation): busy=0, valid=0, o_free_cnt=ROWS, o_alloc_rdy=1, o_alloc_row=0. Data contents are left as-is but are masked by valid.
- Allocation:
  - o_alloc_row is the lowest-index row with busy=0, decoded combinationally from registered busy.
  - o_alloc_rdy = |~busy.
  - i_alloc & o_alloc_rdy sets busy[o_alloc_row] at the next edge.
  - i_alloc with o_alloc_rdy=0 is ignored; no state change and no error.
  - No same-cycle bypass: a row freed in cycle t is allocatable from cycle t+1.
- Write:
  - i_we with busy[i_wrow]=1: for each lane k with i_wmask[k]=1, data[i_wrow*LANES+k] <= lane k data and valid is set at the next edge.
  - Lanes with mask=0 keep their data and valid bit.
  - A write to a non-busy row is dropped entirely.
  - A write to the row being allocated in the same cycle is dropped, because busy is not yet set.
  - i_wrow >= ROWS is dropped.
- Free:
  - For each set bit r of i_free: busy[r] <= 0 and valid[r*LANES +: LANES] <= 0.
  - Freeing an already-free row is a no-op and does not change the count.
  - Free and write to the same row in the same cycle: free wins, and valid ends at 0.
- Flush: i_flush clears all busy and valid bits at the next edge and sets o_free_cnt=ROWS. It overrides alloc, write and free in that cycle.
- Counter:
  - o_free_cnt(next) = o_free_cnt − (alloc accepted) + popcount(i_free & busy).
  - Simultaneous accepted alloc and free of a different row leaves the count unchanged.
  - The count always equals popcount(~busy); the bench asserts this every cycle.
- Read:
  - Purely combinational, zero latency.
  - o_rdata[p] = data[i_raddr[p]]; o_rvalid[p] = valid[i_raddr[p]].
  - No write-to-read bypass: a read in the write cycle returns the old data and valid.
  - Addresses >= SIZE return o_rvalid=0 and o_rdata=0.
  - All RPORTS ports may address the same entry at the same time.

Test Plan:
- Reset, then hold i_alloc=1 for 9 cycles (SIZE=32, LANES=4) -> granted rows 0..7 in order; o_free_cnt counts 8→0; in cycle 9 o_alloc_rdy=0, row is not granted, count stays 0.
- Allocate row 0; write i_wrow=0, i_wmask=4'b0101, lanes 0xA0,0xA1,0xA2,0xA3 -> next cycle reads of addresses 0..3 give rvalid 1,0,1,0 and rdata 0xA0 at addr 0, 0xA2 at addr 2; a same-cycle read still shows the old values.
- Fill rows 0..7, free 3 and 5 (i_free=8'h28) -> o_free_cnt=2, next o_alloc_row=3; after that alloc, o_alloc_row=5; entries 12..15 and 20..23 read rvalid=0.
- Write to free row 6 with mask 4'hF -> all 4 entries of row 6 stay rvalid=0; also write and free row 2 in the same cycle -> row 2 rvalid=0, busy=0.
- With 5 rows busy, pulse i_flush together with i_alloc, i_we and i_free -> next cycle o_free_cnt=8, o_alloc_row=0, every o_rvalid=0.
- Assert i_rst asynchronously between edges mid-burst -> outputs reach reset values before the next edge; allocation restarts at row 0.
